ro_sweep_sequencer: RTL
=======================

// Module: ro_sweep_sequencer
// PURPOSE
//  Measurement sequencer for the ring-oscillator array and its 16:1 output muxes.
//  - Drives the shared ring tap-select vector (s1..s5), the start enable and the mux select.
//  - Gates a window of wb_clk_i cycles and counts rising edges of the selected, muxed oscillator output.
//  - Returns one count per oscillator: a single selected ring, or a sweep of all rings in index order.
// PARAMETERS
//  NUM_RO         16  oscillators behind the mux; the sweep covers indices 0..NUM_RO-1
//  CNT_W          20  edge-counter width; the count saturates at 2^CNT_W-1
//  GATE_W         16  width of the gate-length field
//  SETTLE_CYCLES  16  cycles with start=1 before counting begins (>=1)
// PORTS
//  wb_clk_i       in   1       system clock
//  wb_rst_ni      in   1       asynchronous reset, active-low
//  cmd_valid_i    in   1       command request
//  cmd_ready_o    out  1       high only in IDLE; a command is accepted on valid&ready
//  cmd_sweep_i    in   1       1 = sweep ro 0..NUM_RO-1; 0 = single ro cmd_ro_i
//  cmd_ro_i       in   4       oscillator index for a single measurement
//  cmd_cfg_i      in   5       ring tap-select, bits [4:0] = s5..s1
//  cmd_gate_i     in   GATE_W  gate length in cycles; 0 is treated as 1
//  ro_y_i         in   1       muxed oscillator output, asynchronous
//  ro_start_o     out  1       oscillator start enable
//  ro_cfg_o       out  5       tap-select vector to all rings
//  mux_sel_o      out  4       mux select
//  res_valid_o    out  1       result available
//  res_ready_i    in   1       result accepted on valid&ready
//  res_ro_o       out  4       oscillator index of the result
//  res_count_o    out  CNT_W   rising edges counted in the gate window
//  res_sat_o      out  1       count saturated
//  busy_o         out  1       state != IDLE
// BEHAVIOUR
//  - Reset: all outputs 0, except cmd_ready_o = 1. State = IDLE. Counters and synchronisers cleared.
//  - Command capture: cmd_sweep_i, cmd_ro_i, cmd_cfg_i and cmd_gate_i are registered on accept.
//    The start index is 0 for a sweep and cmd_ro_i for a single measurement.
//  - FSM IDLE -> SETUP: on accept.
//  - FSM SETUP (1 cycle): start=0; drive mux_sel_o and ro_cfg_o; clear the count. This resets the ring.
//  - FSM SETTLE (SETTLE_CYCLES cycles): start=1; edges ignored.
//  - FSM MEASURE (gate cycles): start=1; each detected rising edge adds 1 until the count saturates.
//  - FSM REPORT: res_valid_o=1; all res_* held stable until res_ready_i.
//    On handshake: for a sweep with ro<NUM_RO-1, ro+1 and -> SETUP. Otherwise -> IDLE with start=0.
//  - Edge detect: 2-FF synchroniser, then a previous-value register; edge = sync & ~prev.
//    The detector runs continuously, so no edges are lost at the window boundary.
//  - mux_sel_o and ro_cfg_o stay constant from SETUP through REPORT.
//  - Latency: with the accept edge as cycle 0, res_valid_o rises at cycle 2+SETTLE_CYCLES+G.
//    G = max(cmd_gate_i,1).
//  - Saturation: the count stops at all-ones and res_sat_o=1. res_sat_o clears in SETUP.
//  - Backpressure: REPORT may wait indefinitely; start stays 1 and counting is frozen.
//  - cmd_valid_i while busy is ignored; it is not queued.
//  - Reset mid-operation: asynchronous return to reset values; any pending result is discarded.
// CONFIGURATION
//  - RO_SWEEP_ABORT_EN defined: adds input port abort_i (1 bit).
//    abort_i=1 in any non-IDLE state -> IDLE on the next edge.
//    start=0, res_valid_o=0, no result is emitted, and the remaining sweep entries are dropped.
//    abort_i has no effect in IDLE.
//  - RO_SWEEP_ABORT_EN undefined: no abort_i port; a command always runs to completion.
// TESTING
//  - Single: ro=5, cfg=5'b00011, gate=100, ro_y_i period 10 clk.
//    -> mux_sel_o=5, ro_cfg_o=3, count=10, sat=0; valid at cycle 118 after accept.
//  - Sweep: gate=50, ro_y_i period 5, res_ready_i tied 1.
//    -> 16 results, res_ro_o 0..15 in order, each count=10; then IDLE, start=0.
//  - Saturation: CNT_W=4, gate=100, period 4 -> count=15, sat=1.
//    The next command at period 10, gate=20 -> count=2, sat=0.
//  - Backpressure: res_ready_i held 0 for 30 cycles in a sweep.
//    -> res_* stable, no index skipped; ro+1 enters SETUP the cycle after the handshake.
//  - Gate 0: gate=0, ro_y_i constant 0 -> count=0; valid at cycle 2+SETTLE_CYCLES+1.
//  - Reset/abort: wb_rst_ni low during MEASURE -> outputs 0 immediately, cmd_ready_o=1.
//    With RO_SWEEP_ABORT_EN, abort_i pulsed at sweep ro=7 -> IDLE, no further results.

Source files
------------

// File: rtl/ro_sweep_sequencer.sv
// Ring-oscillator measurement sequencer: gates a window of wb_clk_i cycles and counts muxed ro_y_i rising edges, one ring or a sweep.
// Latency: result valid 2+SETTLE_CYCLES+max(gate,1) cycles after the accept edge. Backpressure: REPORT holds results until res_ready_i.
// Optional abort_i port enabled by defining RO_SWEEP_ABORT_EN.
module ro_sweep_sequencer #(
    parameter int NUM_RO        = 16,
    parameter int CNT_W         = 20,
    parameter int GATE_W        = 16,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_sweep_i,
    input  logic [3:0]        cmd_ro_i,
    input  logic [4:0]        cmd_cfg_i,
    input  logic [GATE_W-1:0] cmd_gate_i,
    input  logic              ro_y_i,
    output logic              ro_start_o,
    output logic [4:0]        ro_cfg_o,
    output logic [3:0]        mux_sel_o,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [3:0]        res_ro_o,
    output logic [CNT_W-1:0]  res_count_o,
    output logic              res_sat_o,
`ifdef RO_SWEEP_ABORT_EN
    input  logic              abort_i,
`endif
    output logic              busy_o
);

    localparam int TW = (GATE_W > $clog2(SETTLE_CYCLES) + 1) ? GATE_W : $clog2(SETTLE_CYCLES) + 1;
    localparam logic [3:0] LAST_RO = 4'(NUM_RO - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SETTLE, MEASURE, LATCH, REPORT} state_t;

    state_t             state_q, state_d;
    logic               sweep_q, sweep_d;
    logic [3:0]         ro_q, ro_d;
    logic [4:0]         cfg_q, cfg_d;
    logic [GATE_W-1:0]  gate_q, gate_d;
    logic [TW-1:0]      tmr_q, tmr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               start_q, start_d;
    logic               vld_q, vld_d;
    logic [CNT_W-1:0]   rcnt_q, rcnt_d;
    logic               sat_q, sat_d;
    logic               sync1_q, sync2_q, prev_q;
    logic               edge_w;
    logic               abort_w;
    logic [TW-1:0]      gate_m1;

`ifdef RO_SWEEP_ABORT_EN
    assign abort_w = abort_i;
`else
    assign abort_w = 1'b0;
`endif

    // Edge detector runs in every state so nothing is lost at the window edges.
    assign edge_w  = sync2_q & ~prev_q;
    assign gate_m1 = (gate_q == '0) ? '0 : (TW'(gate_q) - TW'(1));

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        ro_d    = ro_q;
        cfg_d   = cfg_q;
        gate_d  = gate_q;
        tmr_d   = tmr_q;
        cnt_d   = cnt_q;
        start_d = start_q;
        vld_d   = vld_q;
        rcnt_d  = rcnt_q;
        sat_d   = sat_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    sweep_d = cmd_sweep_i;
                    ro_d    = cmd_sweep_i ? 4'd0 : cmd_ro_i;
                    cfg_d   = cmd_cfg_i;
                    gate_d  = cmd_gate_i;
                    rcnt_d  = '0;
                    sat_d   = 1'b0;
                    start_d = 1'b0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = '0;
                start_d = 1'b1;
                tmr_d   = TW'(SETTLE_CYCLES - 1);
                state_d = SETTLE;
            end
            SETTLE: begin
                if (tmr_q == '0) begin
                    tmr_d   = gate_m1;
                    state_d = MEASURE;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            MEASURE: begin
                if (edge_w && (cnt_q != '1)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (tmr_q == '0) begin
                    state_d = LATCH;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            LATCH: begin
                rcnt_d  = cnt_q;
                sat_d   = &cnt_q;
                vld_d   = 1'b1;
                state_d = REPORT;
            end
            REPORT: begin
                if (res_ready_i) begin
                    vld_d   = 1'b0;
                    start_d = 1'b0;
                    if (sweep_q && (ro_q != LAST_RO)) begin
                        ro_d    = ro_q + 4'd1;
                        rcnt_d  = '0;
                        sat_d   = 1'b0;
                        state_d = SETUP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort_w && (state_q != IDLE)) begin
            state_d = IDLE;
            start_d = 1'b0;
            vld_d   = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
            sweep_q <= 1'b0;
            ro_q    <= '0;
            cfg_q   <= '0;
            gate_q  <= '0;
            tmr_q   <= '0;
            cnt_q   <= '0;
            start_q <= 1'b0;
            vld_q   <= 1'b0;
            rcnt_q  <= '0;
            sat_q   <= 1'b0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            ro_q    <= ro_d;
            cfg_q   <= cfg_d;
            gate_q  <= gate_d;
            tmr_q   <= tmr_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            vld_q   <= vld_d;
            rcnt_q  <= rcnt_d;
            sat_q   <= sat_d;
            sync1_q <= ro_y_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign cmd_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign ro_start_o  = start_q;
    assign ro_cfg_o    = cfg_q;
    assign mux_sel_o   = ro_q;
    assign res_ro_o    = ro_q;
    assign res_valid_o = vld_q;
    assign res_count_o = rcnt_q;
    assign res_sat_o   = sat_q;

endmodule
